// File: rtl/irrigation_sequencer_pkg.sv
// Shared definitions for the irrigation sequencer: state codes, sensor bit
// positions in the sensor vector, counter width and the level-consistency rule.
package irrigation_sequencer_pkg;

  localparam int CNT_W  = 16;
  localparam int N_SENS = 6;

  localparam int SENS_H  = 0;
  localparam int SENS_M  = 1;
  localparam int SENS_L  = 2;
  localparam int SENS_US = 3;
  localparam int SENS_UA = 4;
  localparam int SENS_T  = 5;

  typedef logic [2:0]       state_t;
  typedef logic [CNT_W-1:0] cnt_t;

  localparam state_t ST_INIT     = 3'd0;
  localparam state_t ST_IDLE     = 3'd1;
  localparam state_t ST_FILL     = 3'd2;
  localparam state_t ST_SPRINKLE = 3'd3;
  localparam state_t ST_DRIP     = 3'd4;
  localparam state_t ST_ERROR    = 3'd5;

  // A higher level sensor wet while a lower one is dry means a broken sensor.
  function automatic logic level_bad(input logic h, input logic m, input logic l);
    return (h & ~m) | (m & ~l);
  endfunction

endpackage

// File: rtl/irrigation_sequencer_debounce.sv
// One sensor input: two-flop synchroniser followed by a debouncer that accepts
// a new level only after DEBOUNCE_CYC consecutive identical synced samples.
module irrigation_sequencer_debounce #(
  parameter logic [3:0] DEBOUNCE_CYC = 4'd8
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic clean
);

  logic       sync1_q, sync1_d;
  logic       sync2_q, sync2_d;
  logic       clean_q, clean_d;
  logic [3:0] run_q, run_d;

  // run_q counts consecutive synced samples that disagree with the accepted level.
  always_comb begin
    sync1_d = raw;
    sync2_d = sync1_q;
    clean_d = clean_q;
    run_d   = 4'd0;
    if (sync2_q != clean_q) begin
      if (run_q == DEBOUNCE_CYC - 4'd1) begin
        clean_d = sync2_q;
      end else begin
        run_d = run_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      clean_q <= 1'b0;
      run_q   <= 4'd0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      clean_q <= clean_d;
      run_q   <= run_d;
    end
  end

  assign clean = clean_q;

endmodule

// File: rtl/irrigation_sequencer.sv
// Tank / irrigation controller: debounced sensors feed a Moore FSM that opens
// the inlet, sprinkler or drip valve with run-time limits and a fill timeout.
module irrigation_sequencer
  import irrigation_sequencer_pkg::*;
#(
  parameter logic [3:0]  DEBOUNCE_CYC     = 4'd8,
  parameter logic [15:0] MIN_RUN_CYC      = 16'd200,
  parameter logic [15:0] MAX_RUN_CYC      = 16'd2000,
  parameter logic [15:0] FILL_TIMEOUT_CYC = 16'd4000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       H,
  input  logic       M,
  input  logic       L,
  input  logic       US,
  input  logic       UA,
  input  logic       T,
  input  logic       clr_alarm,
  output logic       valve_in,
  output logic       sprinkler,
  output logic       drip,
  output logic       alarm,
  output logic [2:0] state,
  output logic       busy
);

  localparam cnt_t INIT_END  = {12'd0, DEBOUNCE_CYC} + 16'd3;
  localparam cnt_t FILL_LAST = FILL_TIMEOUT_CYC - 16'd1;
  localparam cnt_t RUN_LAST  = MAX_RUN_CYC - 16'd1;
  localparam cnt_t RUN_MIN   = MIN_RUN_CYC - 16'd1;

  logic [N_SENS-1:0] sens_raw;
  logic [N_SENS-1:0] sens_deb;

  assign sens_raw[SENS_H]  = H;
  assign sens_raw[SENS_M]  = M;
  assign sens_raw[SENS_L]  = L;
  assign sens_raw[SENS_US] = US;
  assign sens_raw[SENS_UA] = UA;
  assign sens_raw[SENS_T]  = T;

  for (genvar i = 0; i < N_SENS; i++) begin : g_deb
    irrigation_sequencer_debounce #(
      .DEBOUNCE_CYC(DEBOUNCE_CYC)
    ) u_deb (
      .clk  (clk),
      .rst  (rst),
      .raw  (sens_raw[i]),
      .clean(sens_deb[i])
    );
  end

  logic h_ok, m_ok, l_ok, soil_wet, air_humid, hot, bad;

  assign h_ok      = sens_deb[SENS_H];
  assign m_ok      = sens_deb[SENS_M];
  assign l_ok      = sens_deb[SENS_L];
  assign soil_wet  = sens_deb[SENS_US];
  assign air_humid = sens_deb[SENS_UA];
  assign hot       = sens_deb[SENS_T];
  assign bad       = level_bad(h_ok, m_ok, l_ok);

  state_t state_q, state_d;
  cnt_t   cnt_q, cnt_d;

  // Fault beats disable, disable beats the per-state rule; ERROR ignores en.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_INIT: begin
        if (cnt_q == INIT_END) state_d = ST_IDLE;
      end
      ST_IDLE, ST_FILL, ST_SPRINKLE, ST_DRIP, ST_ERROR: begin
        if (bad) begin
          state_d = ST_ERROR;
        end else if (state_q == ST_ERROR) begin
          if (clr_alarm) state_d = ST_IDLE;
        end else if (!en) begin
          state_d = ST_IDLE;
        end else begin
          case (state_q)
            ST_IDLE: begin
              if (!l_ok)          state_d = ST_FILL;
              else if (!soil_wet) state_d = (hot | ~air_humid) ? ST_DRIP : ST_SPRINKLE;
            end
            ST_FILL: begin
              if (h_ok)                    state_d = ST_IDLE;
              else if (cnt_q == FILL_LAST) state_d = ST_ERROR;
            end
            ST_SPRINKLE, ST_DRIP: begin
              if (!l_ok)                             state_d = ST_FILL;
              else if (cnt_q == RUN_LAST)            state_d = ST_IDLE;
              else if (soil_wet && cnt_q >= RUN_MIN) state_d = ST_IDLE;
            end
            default: state_d = state_q;
          endcase
        end
      end
      default: state_d = ST_ERROR;
    endcase
  end

  always_comb begin
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (cnt_q == 16'hFFFF) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Decoded from the state register alone so the valves close as soon as reset asserts.
  assign valve_in  = (state_q == ST_FILL);
  assign sprinkler = (state_q == ST_SPRINKLE);
  assign drip      = (state_q == ST_DRIP);
  assign alarm     = (state_q == ST_ERROR);
  assign busy      = valve_in | sprinkler | drip;
  assign state     = state_q;

endmodule

// File: tb/tb_irrigation_sequencer.sv
// Self-checking bench for irrigation_sequencer: a cycle model pushes the
// expected state/outputs per clock into a scoreboard, popped after each edge.
module tb_irrigation_sequencer;

  localparam int D    = 4;
  localparam int MINR = 10;
  localparam int MAXR = 50;
  localparam int FT   = 30;

  logic       clk = 1'b0;
  logic       rst, en, H, M, L, US, UA, T, clr_alarm;
  logic       valve_in, sprinkler, drip, alarm, busy;
  logic [2:0] state;

  irrigation_sequencer #(
    .DEBOUNCE_CYC    (4'd4),
    .MIN_RUN_CYC     (16'd10),
    .MAX_RUN_CYC     (16'd50),
    .FILL_TIMEOUT_CYC(16'd30)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .H        (H),
    .M        (M),
    .L        (L),
    .US       (US),
    .UA       (UA),
    .T        (T),
    .clr_alarm(clr_alarm),
    .valve_in (valve_in),
    .sprinkler(sprinkler),
    .drip     (drip),
    .alarm    (alarm),
    .state    (state),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cycle  = 0;
  logic [7:0] expQ[$];

  int         mState, mCnt;
  logic [5:0] mS1, mS2, mDeb, mLast;
  int         mRun[6];

  // Count one comparison and report it if the observed value differs.
  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s cycle=%0d got=0x%0h expected=0x%0h", tag, cycle, actual, expected);
    end
  endtask

  function automatic logic [7:0] encode(input int st);
    logic [2:0] s;
    s = st[2:0];
    return {s, st == 2, st == 3, st == 4, st == 5, (st >= 2 && st <= 4)};
  endfunction

  task automatic modelReset();
    mState = 0;
    mCnt   = 0;
    mS1    = '0;
    mS2    = '0;
    mDeb   = '0;
    mLast  = '0;
    for (int i = 0; i < 6; i++) mRun[i] = 0;
  endtask

  // Advance the reference model by one clock using the inputs as currently driven.
  task automatic modelStep();
    logic [5:0] raw;
    logic       bad;
    int         ns;
    raw = {T, UA, US, L, M, H};
    bad = (mDeb[0] & ~mDeb[1]) | (mDeb[1] & ~mDeb[2]);
    ns  = mState;
    if (mState == 0) begin
      if (mCnt == D + 3) ns = 1;
    end else if (mState > 5) begin
      ns = 5;
    end else if (bad) begin
      ns = 5;
    end else if (mState == 5) begin
      if (clr_alarm) ns = 1;
    end else if (!en) begin
      ns = 1;
    end else if (mState == 1) begin
      if (!mDeb[2])      ns = 2;
      else if (!mDeb[3]) ns = (mDeb[5] || !mDeb[4]) ? 4 : 3;
    end else if (mState == 2) begin
      if (mDeb[0])           ns = 1;
      else if (mCnt == FT-1) ns = 5;
    end else begin
      if (!mDeb[2])                       ns = 2;
      else if (mCnt == MAXR-1)            ns = 1;
      else if (mDeb[3] && mCnt >= MINR-1) ns = 1;
    end
    if (ns != mState)      mCnt = 0;
    else if (mCnt < 65535) mCnt = mCnt + 1;
    mState = ns;
    for (int i = 0; i < 6; i++) begin
      if (mRun[i] > 0 && mS2[i] == mLast[i]) mRun[i] = mRun[i] + 1;
      else                                   mRun[i] = 1;
      mLast[i] = mS2[i];
      if (mRun[i] >= D && mS2[i] != mDeb[i]) mDeb[i] = mS2[i];
    end
    mS2 = mS1;
    mS1 = raw;
    expQ.push_back(encode(mState));
  endtask

  task automatic applyStimulus(input int n);
    logic [7:0] exp;
    for (int k = 0; k < n; k++) begin
      modelStep();
      @(posedge clk);
      #1;
      cycle++;
      exp = expQ.pop_front();
      checkOutput("outs", {24'd0, state, valve_in, sprinkler, drip, alarm, busy}, {24'd0, exp});
    end
  endtask

  task automatic waitState(input logic [2:0] target, input int budget);
    int k;
    k = 0;
    while (state != target && k < budget) begin
      applyStimulus(1);
      k++;
    end
    checkOutput($sformatf("reach_st%0d", target), {29'd0, state}, {29'd0, target});
  endtask

  // Length of the current visit to st, counting the observation already made.
  task automatic measureRun(input logic [2:0] st, input int budget, output int n);
    bit done;
    n    = (state == st) ? 1 : 0;
    done = 1'b0;
    for (int k = 0; k < budget && !done; k++) begin
      applyStimulus(1);
      if (state == st) n++;
      else             done = 1'b1;
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog cycle=%0d", cycle);
    $fatal(1, "[TB] simulation time limit reached");
  end

  initial begin
    int n;
    rst = 1'b1; en = 1'b1; clr_alarm = 1'b0;
    H = 1'b0; M = 1'b0; L = 1'b0; US = 1'b0; UA = 1'b0; T = 1'b0;
    modelReset();
    #1;
    checkOutput("rst_state", {29'd0, state}, 32'd0);
    checkOutput("rst_outs", {27'd0, valve_in, sprinkler, drip, alarm, busy}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Empty tank: INIT, IDLE, then FILL; filling completes when H arrives.
    waitState(3'd2, 20);
    checkOutput("valve_in_fill", {31'd0, valve_in}, 32'd1);
    H = 1'b1; M = 1'b1; L = 1'b1; US = 1'b1;
    waitState(3'd1, 8);
    checkOutput("valve_in_idle", {31'd0, valve_in}, 32'd0);

    // Sprinkler run with soil turning wet early: minimum run still enforced.
    UA = 1'b1; T = 1'b0; US = 1'b0;
    waitState(3'd3, 12);
    applyStimulus(3);
    checkOutput("sprinkler_on", {31'd0, sprinkler}, 32'd1);
    US = 1'b1; T = 1'b1;
    measureRun(3'd3, 20, n);
    checkOutput("sprinkle_len", 32'(3 + n), 32'd10);
    checkOutput("sprinkle_exit", {29'd0, state}, 32'd1);

    // Drip run hitting the maximum run time, then immediate re-entry.
    US = 1'b0;
    waitState(3'd4, 12);
    measureRun(3'd4, 60, n);
    checkOutput("drip_len", 32'(n), 32'd50);
    checkOutput("drip_max_exit", {29'd0, state}, 32'd1);
    applyStimulus(1);
    checkOutput("drip_reenter", {29'd0, state}, 32'd4);

    // Tank drains mid-drip, then en drops during FILL.
    H = 1'b0; M = 1'b0; L = 1'b0;
    waitState(3'd2, 10);
    applyStimulus(2);
    en = 1'b0;
    applyStimulus(1);
    checkOutput("en_off_state", {29'd0, state}, 32'd1);
    checkOutput("en_off_valve", {31'd0, valve_in}, 32'd0);
    applyStimulus(3);
    en = 1'b1;

    // Fill timeout, then alarm clear blocked while levels are inconsistent.
    waitState(3'd2, 4);
    measureRun(3'd2, 40, n);
    checkOutput("fill_len", 32'(n), 32'd30);
    checkOutput("timeout_state", {29'd0, state}, 32'd5);
    checkOutput("timeout_alarm", {31'd0, alarm}, 32'd1);
    M = 1'b1;
    applyStimulus(8);
    clr_alarm = 1'b1;
    applyStimulus(1);
    clr_alarm = 1'b0;
    applyStimulus(2);
    checkOutput("clr_while_bad", {29'd0, state}, 32'd5);
    L = 1'b1;
    applyStimulus(8);
    clr_alarm = 1'b1;
    applyStimulus(1);
    clr_alarm = 1'b0;
    checkOutput("clr_ok_state", {29'd0, state}, 32'd1);
    checkOutput("clr_ok_alarm", {31'd0, alarm}, 32'd0);

    // Short soil glitch in IDLE must not start a run.
    US = 1'b1;
    waitState(3'd1, 20);
    applyStimulus(10);
    US = 1'b0;
    applyStimulus(3);
    US = 1'b1;
    applyStimulus(10);
    checkOutput("glitch_idle", {29'd0, state}, 32'd1);

    // Asynchronous reset during a sprinkler run.
    T = 1'b0; UA = 1'b1; US = 1'b0;
    waitState(3'd3, 12);
    applyStimulus(3);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async_rst_spr", {31'd0, sprinkler}, 32'd0);
    checkOutput("async_rst_state", {29'd0, state}, 32'd0);
    modelReset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    applyStimulus(20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
